// File: rtl/lookahead_grant_sequencer_pkg.sv
// Shared types and constants for the lookahead grant sequencer: state encoding,
// client count, default grant timeout and a reference round-robin pick.
package lookahead_grant_sequencer_pkg;

  localparam int N_CLIENTS       = 66;
  localparam int TIMEOUT_DEFAULT = 15;
  localparam int IDX_W           = $clog2(N_CLIENTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Lowest set index at or above ptr, else lowest set index overall.
  function automatic pick_t rr_pick(input logic [N_CLIENTS-1:0] pending,
                                    input logic [IDX_W-1:0]     ptr);
    pick_t            res;
    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    res      = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(i);
        if (ptr <= IDX_W'(i)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    if (hi_found) res.idx = hi_idx;
    return res;
  endfunction

endpackage

// File: rtl/lookahead_grant_sequencer_rr_find_first.sv
// Combinational wrapped priority search: first set request at or after ptr,
// wrapping around, done as a find-first over a double-width masked vector.
module lookahead_grant_sequencer_rr_find_first #(
  parameter int N  = 66,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int PW = $clog2(2 * N);

  logic [N-1:0]   lo_mask;
  logic [2*N-1:0] dbl;
  logic [PW-1:0]  pos;

  // The lower copy only keeps requests at or above ptr; the upper copy is the
  // full vector, so a miss in the lower half naturally wraps to index 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = (ptr <= IW'(i));
    end
    dbl = {req, req & lo_mask};
  end

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    pos = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) pos = PW'(i);
    end
  end

  assign found = |req;
  assign idx   = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);

endmodule

// File: rtl/lookahead_grant_sequencer.sv
// Captures an enable snapshot and serializes it into one-hot, round-robin
// grants, each closed by a client acknowledge or a timeout.
module lookahead_grant_sequencer
  import lookahead_grant_sequencer_pkg::*;
#(
  parameter int N       = N_CLIENTS,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  en_vec,
  input  logic          en_valid,
  input  logic          flush,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  input  logic          gnt_ack,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic          overrun
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q,   state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [IW-1:0] ptr_q,     ptr_d;
  logic [IW-1:0] cur_q,     cur_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          tmo_last;

  lookahead_grant_sequencer_rr_find_first #(
    .N  (N),
    .IW (IW)
  ) u_find (
    .req   (pending_q),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign tmo_last = (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    tmo_cnt_d   = tmo_cnt_q;
    done        = 1'b0;
    timeout_err = 1'b0;
    overrun     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_valid) begin
          pending_d = en_vec;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        overrun = en_valid;
        if (!pick_found) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cur_d     = pick_idx;
          tmo_cnt_d = '0;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        overrun = en_valid;
        // An ack arriving on the final timeout cycle still counts as accepted.
        if (gnt_ack || tmo_last) begin
          pending_d[cur_q] = 1'b0;
          ptr_d            = (cur_q == IW'(N - 1)) ? '0 : cur_q + IW'(1);
          timeout_err      = !gnt_ack;
          state_d          = ST_SCAN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush abandons the batch outright; ptr keeps only completed grants.
    if (flush) begin
      pending_d   = '0;
      ptr_d       = ptr_q;
      state_d     = ST_IDLE;
      done        = 1'b0;
      timeout_err = 1'b0;
      overrun     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      cur_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_idx   = gnt_valid ? cur_q : '0;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[cur_q] = 1'b1;
  end

endmodule

// File: tb/tb_lookahead_grant_sequencer.sv
// Scoreboard bench for lookahead_grant_sequencer: a reference model predicts
// grant order and per-grant outcome, a monitor compares what the DUT presents.
module tb_lookahead_grant_sequencer;

  localparam int N       = 66;
  localparam int TIMEOUT = 15;
  localparam int IW      = $clog2(N);
  localparam int BUDGET  = N * (TIMEOUT + 3) + 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  en_vec = '0;
  logic          en_valid = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          gnt_ack = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic          overrun;

  lookahead_grant_sequencer #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_vec      (en_vec),
    .en_valid    (en_valid),
    .flush       (flush),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .gnt_ack     (gnt_ack),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    bit tmo;
  } outcome_t;

  int       exp_idx[$];
  outcome_t exp_out[$];
  int       grant_starts[$];
  int       done_cycles[$];
  int       pass_cnt = 0;
  int       chk_cnt  = 0;
  int       cyc      = 0;
  int       model_ptr = 0;
  int       forced_delay = 0;
  bit       mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Grant order is the set bits visited upward from ptr, wrapping once.
  function automatic void model_capture(input logic [N-1:0] v);
    int start = model_ptr;
    int last  = -1;
    for (int k = 0; k < N; k++) begin
      int i = (start + k) % N;
      if (v[i]) begin
        exp_idx.push_back(i);
        last = i;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % N;
  endfunction

  // Client responder: acks each grant after a chosen delay, noise otherwise.
  int rsp_n = 0;
  int rsp_d = 0;
  bit rsp_in = 1'b0;
  always @(posedge clk) begin
    #1;
    if (gnt_valid) begin
      if (!rsp_in) begin
        outcome_t o;
        rsp_in = 1'b1;
        rsp_n  = 1;
        rsp_d  = (forced_delay < 0) ? int'($urandom_range(0, TIMEOUT + 1)) : forced_delay;
        o.len  = (rsp_d < TIMEOUT) ? rsp_d + 1 : TIMEOUT;
        o.tmo  = (rsp_d >= TIMEOUT);
        exp_out.push_back(o);
      end else begin
        rsp_n++;
      end
      gnt_ack = (rsp_n == rsp_d + 1);
    end else begin
      rsp_in  = 1'b0;
      gnt_ack = $urandom_range(0, 1) == 1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or done.
  bit           mon_prev = 1'b0;
  int           mon_len = 0;
  int           mon_tmo_at = 0;
  int           mon_exp_i = 0;
  outcome_t     mon_o;
  logic [N-1:0] mon_oh;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (gnt_valid && !mon_prev) begin
        grant_starts.push_back(cyc);
        mon_exp_i = (exp_idx.size() != 0) ? exp_idx.pop_front() : -1;
        mon_oh = '0;
        if (mon_exp_i >= 0) mon_oh[mon_exp_i] = 1'b1;
        check("grant_idx", gnt_idx, mon_exp_i);
        check("grant_onehot", gnt, mon_oh);
        if (exp_out.size() != 0) mon_o = exp_out.pop_front();
        else begin
          mon_o.len = -1;
          mon_o.tmo = 1'b0;
        end
        mon_len    = 0;
        mon_tmo_at = 0;
      end
      if (gnt_valid) begin
        mon_len++;
        if (timeout_err) mon_tmo_at = mon_len;
      end else if (mon_prev) begin
        check("grant_len", mon_len, mon_o.len);
        check("timeout_pos", mon_tmo_at, mon_o.tmo ? mon_o.len : 0);
      end
      if (timeout_err && !gnt_valid) check("timeout_outside_grant", timeout_err, 1'b0);
      if (!gnt_valid && gnt != '0) check("gnt_idle_zero", gnt, '0);
      if (done) begin
        done_cycles.push_back(cyc);
        check("done_after_all_grants", exp_idx.size(), 0);
      end
    end
    mon_prev = gnt_valid;
  end

  task automatic batch(input logic [N-1:0] v, input int delay, output int cap);
    @(posedge clk);
    #1;
    forced_delay = delay;
    en_vec   = v;
    en_valid = 1'b1;
    cap      = cyc;
    model_capture(v);
    @(posedge clk);
    #1;
    en_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0 = done_cycles.size();
    int k  = 0;
    while (done_cycles.size() == n0 && k < BUDGET) begin
      @(posedge clk);
      k++;
    end
    if (done_cycles.size() == n0) check("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_gv();
    int k = 0;
    while (!gnt_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("grant_seen", gnt_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cap;
    int           n_gs;
    int           n_dc;
    int           saved_ptr;
    bit           saw_done;
    logic [N-1:0] v;

    // Reset state.
    @(negedge clk);
    check("rst_gnt_valid", gnt_valid, 1'b0);
    check("rst_outputs", {gnt, gnt_idx, busy, done, timeout_err, overrun}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // {3,10,65} with immediate acks: grants at +2,+4,+6, done at +7.
    n_gs = grant_starts.size();
    n_dc = done_cycles.size();
    v = '0; v[3] = 1'b1; v[10] = 1'b1; v[65] = 1'b1;
    batch(v, 0, cap);
    wait_done();
    check("t1_num_grants", grant_starts.size() - n_gs, 3);
    check("t1_g0_cycle", grant_starts[n_gs] - cap, 2);
    check("t1_g1_cycle", grant_starts[n_gs + 1] - cap, 4);
    check("t1_g2_cycle", grant_starts[n_gs + 2] - cap, 6);
    check("t1_done_cycle", done_cycles[n_dc] - cap, 7);

    // Walk ptr to 11, then {0,5,12} must come out 12,0,5.
    v = '0; v[10] = 1'b1;
    batch(v, 0, cap);
    wait_done();
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[12] = 1'b1;
    batch(v, -1, cap);
    wait_done();

    // Unacked grant on bit 7: full timeout, done one cycle after.
    v = '0; v[7] = 1'b1;
    batch(v, 1000, cap);
    wait_done();
    check("to_done_after_drop", done_cycles[done_cycles.size() - 1]
                                - grant_starts[grant_starts.size() - 1], TIMEOUT);

    // Empty snapshot: done one cycle after capture, no grant.
    n_gs = grant_starts.size();
    batch('0, 0, cap);
    wait_done();
    check("empty_done_cycle", done_cycles[done_cycles.size() - 1] - cap, 1);
    check("empty_no_grant", grant_starts.size() - n_gs, 0);

    // Capture strobe during a live grant: overrun pulse, sequence unchanged.
    v = '0; v[2] = 1'b1; v[40] = 1'b1; v[50] = 1'b1;
    batch(v, 3, cap);
    wait_gv();
    en_vec   = '1;
    en_valid = 1'b1;
    @(negedge clk);
    check("overrun_pulse", overrun, 1'b1);
    @(posedge clk);
    #1;
    en_valid = 1'b0;
    @(negedge clk);
    check("overrun_single", overrun, 1'b0);
    wait_done();

    // Ack on the last timeout cycle wins: full-length grant, no timeout_err.
    v = '0; v[60] = 1'b1;
    batch(v, TIMEOUT - 1, cap);
    wait_done();

    // Flush in the middle of the first grant of {20,30}.
    saved_ptr = model_ptr;
    mon_en = 1'b0;
    v = '0; v[20] = 1'b1; v[30] = 1'b1;
    batch(v, 1000, cap);
    wait_gv();
    check("flush_first_idx", gnt_idx, 20);
    @(posedge clk);
    #1;
    flush    = 1'b1;
    en_valid = 1'b1;
    en_vec   = '1;
    @(negedge clk);
    check("flush_no_done", done, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    en_valid = 1'b0;
    check("flush_gnt_valid", gnt_valid, 1'b0);
    check("flush_gnt", gnt, '0);
    check("flush_busy", busy, 1'b0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("flush_no_done_later", saw_done, 1'b0);
    model_ptr = saved_ptr;
    exp_idx.delete();
    exp_out.delete();
    mon_en = 1'b1;

    // ptr retained across the flush: {25,62} from ptr 61 gives 62 then 25.
    v = '0; v[25] = 1'b1; v[62] = 1'b1;
    batch(v, -1, cap);
    wait_done();

    // Random batches with random ack delays (some beyond the timeout).
    for (int r = 0; r < 6; r++) begin
      v = N'({$urandom(), $urandom(), $urandom()} & {$urandom(), $urandom(), $urandom()});
      batch(v, -1, cap);
      wait_done();
    end

    // Asynchronous reset in the middle of a grant.
    mon_en = 1'b0;
    v = '0; v[5] = 1'b1; v[9] = 1'b1;
    batch(v, 1000, cap);
    wait_gv();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt_valid", gnt_valid, 1'b0);
    check("arst_outputs", {gnt, gnt_idx, busy, done, timeout_err, overrun}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_idx.delete();
    exp_out.delete();
    model_ptr = 0;
    mon_en = 1'b1;

    // First batch after reset starts from ptr 0.
    v = '0; v[5] = 1'b1; v[64] = 1'b1;
    batch(v, -1, cap);
    wait_done();

    repeat (3) @(negedge clk);
    check("queues_drained", exp_idx.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
